dvp_apb_regs_mc: RTL
====================

Name: dvp_apb_regs_mc

Overview:
- Next-generation DVP control/status register file, parametrised for NUM_CH video channels. Sits on the peripheral bus and drives the VI/VP/VO pipeline configuration for each channel.
- Adds over the single-channel block:
  - sticky W1C status;
  - frame counters;
  - vsync-synchronised shadow registers for START/END/SCALER;
  - programmable wait states and error response;
  - interrupt output.

Parameters:
NUM_CH, 2, number of video channels (1..8)
ADDR_W, 6, word-address width of io_ahb_PADDR; must satisfy 2^ADDR_W > NUM_CH*8
FCNT_W, 16, frame counter width (1..32)
WAIT_STATES, 0, PREADY-low cycles inserted in every access phase (0..15)

Ports:
io_ahb_PCLK  in  1  clock
io_ahb_PRESETn  in  1  asynchronous active-low reset
io_ahb_PADDR  in  ADDR_W  word address
io_ahb_PSEL  in  1  select
io_ahb_PENABLE  in  1  access phase
io_ahb_PWRITE  in  1  1=write
io_ahb_PWDATA  in  32  write data
io_ahb_PREADY  out  1  transfer complete
io_ahb_PRDATA  out  32  read data
io_ahb_PSLVERROR  out  1  unmapped-address error
i_vsync  in  NUM_CH  per-channel vsync level, synchronous to PCLK
i_frame_done  in  NUM_CH  one-cycle frame-complete pulses
i_overflow  in  NUM_CH  one-cycle FIFO-overflow pulses
i_busy  in  NUM_CH  live busy level
o_cr  out  32*NUM_CH  CR per channel; channel c in bits [32c+31:32c]
o_start / o_end / o_scaler  out  32*NUM_CH each  active (post-shadow) copies
o_irq  out  1  level interrupt

Behaviour:
- Reset: all registers, counters, sticky bits, pending flags, and the vsync delay flop clear to 0. Outputs: o_* = 0, PREADY = 1 (if WAIT_STATES = 0, otherwise 0), PRDATA = 0, PSLVERROR = 0.
- Map: channel c base = c*8 words.
  - +0 CR (RW). Bit 0 EN, [2:1] MODE, [4:3] FILTER, 5 CUT, 6 IE_FRAME, 7 IE_OVF; the other bits are stored.
  - +1 SR. Bit 0 FRAME_DONE (sticky, W1C), bit 1 OVF (sticky, W1C), bit 2 BUSY (live, RO), bit 3 PENDING (RO).
  - +2 START, +3 END, +4 SCALER (RW, shadowed; reads return the shadow value).
  - +5 FRAME_CNT (RO, zero-extended; any write clears it).
  - +6 and +7 read 0 and ignore writes.
  - Word NUM_CH*8 is GIRQ (RO): bit c = channel c interrupt.
  - Any other address is unmapped.
- Handshake: an access phase is PSEL&PENABLE. A wait counter loads WAIT_STATES on the first access-phase cycle, and PREADY is low while the counter is nonzero. The transfer commits on the cycle with PSEL&PENABLE&PREADY: the write takes effect on that edge, and PRDATA is valid in that cycle (combinational, 0 otherwise). The counter re-arms when PSEL drops or the access completes.
- PSLVERROR = 1 only in the completing cycle of an unmapped access. An unmapped write changes nothing; an unmapped read returns 0.
- Shadowing: a write to START/END/SCALER updates the shadow and sets PENDING.
  - A vsync rising edge (i_vsync & ~vsync_d) with PENDING copies all three shadows to the active copies, then clears PENDING.
  - If CR.EN = 0, writes go to shadow and active in the same edge and PENDING is not set.
  - A write on the same edge as the vsync rise: active receives the pre-write shadow, the shadow takes the new data, and PENDING stays 1.
- Sticky bits: set on the hardware pulse, cleared by writing 1 to that bit position. If a set and a clear occur on the same edge, set wins.
- FRAME_CNT: +1 per i_frame_done, wraps from 2^FCNT_W-1 to 0. A clear-write on the same edge as a pulse results in 1.
- Interrupt: channel irq = (FRAME_DONE & IE_FRAME) | (OVF & IE_OVF). o_irq = OR of all channel irqs, registered (one cycle after the sticky bit is set).
- Reset asserted mid-transfer: everything returns to reset state immediately; no partial write.

Optional Feature:
- DVP_IRQ_EN defined: interrupt logic as specified.
- Undefined: o_irq tied 0, GIRQ reads 0, and CR bits 6/7 are still stored but have no effect.

Test Plan:
- Reset, then read CR0, SR0, GIRQ with WAIT_STATES=0 -> all 0, PREADY=1, PSLVERROR=0.
- WAIT_STATES=2: write CR1=0x1 -> PREADY low for 2 access cycles, then high; readback 0x1. Read word 63 -> PRDATA=0, PSLVERROR=1 in the completing cycle.
- CR0.EN=1, write START0=0x00100020 -> o_start ch0 unchanged and SR0.PENDING=1. Raise i_vsync[0] -> o_start ch0=0x00100020 one edge later, PENDING=0.
- CR0=0x41, pulse i_frame_done[0] -> SR0=0x1, FRAME_CNT0=1, o_irq=1 next cycle. Write SR0=0x1 -> o_irq=0. A W1C coinciding with a new pulse -> bit stays 1.
- FCNT_W=4: 16 frame_done pulses -> FRAME_CNT wraps to 0. A write-clear coinciding with a pulse -> reads 1.
- Assert PRESETn low mid-write of CR0=0xFF -> CR0=0, o_cr=0 immediately; no write after release.

Source files
------------

// File: rtl/dvp_apb_regs_mc.sv
// Multi-channel DVP control/status register file on an APB-style bus, with shadowed
// geometry registers, sticky W1C status and frame counters. Define DVP_IRQ_EN for interrupts.
module dvp_apb_regs_mc #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 6,
  parameter int FCNT_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                   io_ahb_PCLK,
  input  logic                   io_ahb_PRESETn,
  input  logic [ADDR_W-1:0]      io_ahb_PADDR,
  input  logic                   io_ahb_PSEL,
  input  logic                   io_ahb_PENABLE,
  input  logic                   io_ahb_PWRITE,
  input  logic [31:0]            io_ahb_PWDATA,
  output logic                   io_ahb_PREADY,
  output logic [31:0]            io_ahb_PRDATA,
  output logic                   io_ahb_PSLVERROR,
  input  logic [NUM_CH-1:0]      i_vsync,
  input  logic [NUM_CH-1:0]      i_frame_done,
  input  logic [NUM_CH-1:0]      i_overflow,
  input  logic [NUM_CH-1:0]      i_busy,
  output logic [32*NUM_CH-1:0]   o_cr,
  output logic [32*NUM_CH-1:0]   o_start,
  output logic [32*NUM_CH-1:0]   o_end,
  output logic [32*NUM_CH-1:0]   o_scaler,
  output logic                   o_irq
);

  localparam int               CH_W      = ADDR_W - 3;
  localparam logic [ADDR_W-1:0] GIRQ_ADDR = ADDR_W'(NUM_CH * 8);
  localparam logic [3:0]       WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  // Handshake: PSEL&PENABLE is the access phase; PREADY acts as ready and the transfer
  // commits on the edge ending the cycle where PSEL&PENABLE&PREADY are all high.
  logic            access;
  logic            complete;
  logic            wr_en;
  logic            rd_en;
  logic            wait_armed;
  logic [3:0]      wait_cnt;

  assign access           = io_ahb_PSEL & io_ahb_PENABLE;
  assign io_ahb_PREADY    = (WAIT_STATES == 0) || (wait_armed && (wait_cnt == 4'd0));
  assign complete         = access & io_ahb_PREADY;
  assign wr_en            = complete & io_ahb_PWRITE;
  assign rd_en            = complete & ~io_ahb_PWRITE;

  always_ff @(posedge io_ahb_PCLK or negedge io_ahb_PRESETn) begin
    if (!io_ahb_PRESETn) begin
      wait_armed <= 1'b0;
      wait_cnt   <= 4'd0;
    end else if (!io_ahb_PSEL || complete) begin
      wait_armed <= 1'b0;
      wait_cnt   <= 4'd0;
    end else if (access && !wait_armed) begin
      wait_armed <= 1'b1;
      wait_cnt   <= WAIT_LOAD;
    end else if (access && (wait_cnt != 4'd0)) begin
      wait_cnt   <= wait_cnt - 4'd1;
    end
  end

  logic [2:0]      off;
  logic [CH_W-1:0] sel_ch;
  logic            chan_hit;
  logic            girq_hit;

  assign off              = io_ahb_PADDR[2:0];
  assign sel_ch           = io_ahb_PADDR[ADDR_W-1:3];
  assign chan_hit         = io_ahb_PADDR < GIRQ_ADDR;
  assign girq_hit         = io_ahb_PADDR == GIRQ_ADDR;
  assign io_ahb_PSLVERROR = complete & ~(chan_hit | girq_hit);

  logic [NUM_CH-1:0][31:0] ch_rdata;
`ifdef DVP_IRQ_EN
  logic [NUM_CH-1:0]       irq_vec;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [31:0]       cr_q;
    logic [31:0]       start_sh;
    logic [31:0]       end_sh;
    logic [31:0]       scl_sh;
    logic [31:0]       start_act;
    logic [31:0]       end_act;
    logic [31:0]       scl_act;
    logic              fd_q;
    logic              ovf_q;
    logic              pend_q;
    logic              vsync_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic              sel;
    logic              vs_rise;
    logic              sh_wr;
    logic              sr_wr;
    logic              cnt_clr;
    logic [31:0]       rdata_c;

    assign sel     = wr_en & chan_hit & (sel_ch == CH_W'(c));
    assign vs_rise = i_vsync[c] & ~vsync_d;
    assign sh_wr   = sel & ((off == 3'd2) | (off == 3'd3) | (off == 3'd4));
    assign sr_wr   = sel & (off == 3'd1);
    assign cnt_clr = sel & (off == 3'd5);

    always_ff @(posedge io_ahb_PCLK or negedge io_ahb_PRESETn) begin
      if (!io_ahb_PRESETn) begin
        cr_q      <= '0;
        start_sh  <= '0;
        end_sh    <= '0;
        scl_sh    <= '0;
        start_act <= '0;
        end_act   <= '0;
        scl_act   <= '0;
        fd_q      <= 1'b0;
        ovf_q     <= 1'b0;
        pend_q    <= 1'b0;
        vsync_d   <= 1'b0;
        fcnt_q    <= '0;
      end else begin
        vsync_d <= i_vsync[c];
        if (sel && (off == 3'd0)) cr_q <= io_ahb_PWDATA;
        // Hardware set wins over a same-edge W1C.
        fd_q  <= i_frame_done[c] | (fd_q & ~(sr_wr & io_ahb_PWDATA[0]));
        ovf_q <= i_overflow[c] | (ovf_q & ~(sr_wr & io_ahb_PWDATA[1]));
        if (i_frame_done[c]) fcnt_q <= cnt_clr ? FCNT_W'(1) : fcnt_q + FCNT_W'(1);
        else if (cnt_clr)    fcnt_q <= '0;
        if (vs_rise && pend_q) begin
          start_act <= start_sh;
          end_act   <= end_sh;
          scl_act   <= scl_sh;
          pend_q    <= 1'b0;
        end
        // A same-edge write re-arms PENDING; the commit above still used the old shadow.
        if (sh_wr) begin
          if (cr_q[0]) pend_q <= 1'b1;
          case (off)
            3'd2: begin
              start_sh <= io_ahb_PWDATA;
              if (!cr_q[0]) start_act <= io_ahb_PWDATA;
            end
            3'd3: begin
              end_sh <= io_ahb_PWDATA;
              if (!cr_q[0]) end_act <= io_ahb_PWDATA;
            end
            default: begin
              scl_sh <= io_ahb_PWDATA;
              if (!cr_q[0]) scl_act <= io_ahb_PWDATA;
            end
          endcase
        end
      end
    end

    always_comb begin
      rdata_c = '0;
      case (off)
        3'd0:    rdata_c = cr_q;
        3'd1:    rdata_c = {28'd0, pend_q, i_busy[c], ovf_q, fd_q};
        3'd2:    rdata_c = start_sh;
        3'd3:    rdata_c = end_sh;
        3'd4:    rdata_c = scl_sh;
        3'd5:    rdata_c = 32'(fcnt_q);
        default: rdata_c = '0;
      endcase
    end

    assign ch_rdata[c]           = rdata_c;
    assign o_cr[32*c +: 32]      = cr_q;
    assign o_start[32*c +: 32]   = start_act;
    assign o_end[32*c +: 32]     = end_act;
    assign o_scaler[32*c +: 32]  = scl_act;
`ifdef DVP_IRQ_EN
    assign irq_vec[c] = (fd_q & cr_q[6]) | (ovf_q & cr_q[7]);
`endif
  end

  logic [31:0] ch_data;
  logic [31:0] girq_word;
  logic [31:0] rdata;

`ifdef DVP_IRQ_EN
  assign girq_word = 32'(irq_vec);

  always_ff @(posedge io_ahb_PCLK or negedge io_ahb_PRESETn) begin
    if (!io_ahb_PRESETn) o_irq <= 1'b0;
    else                 o_irq <= |irq_vec;
  end
`else
  assign girq_word = '0;
  assign o_irq     = 1'b0;
`endif

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ch == CH_W'(i)) ch_data = ch_rdata[i];
    end
    rdata = '0;
    if (chan_hit)      rdata = ch_data;
    else if (girq_hit) rdata = girq_word;
    io_ahb_PRDATA = rd_en ? rdata : '0;
  end

endmodule
